code_entry_ctrl: RTL and testbench
==================================

# code_entry_ctrl

Sequencing controller for the safe's three-step code entry. It owns the two-digit BCD dial value and the current step index, and drives both into the digit comparator. It samples the comparator's `eq` on each confirm press and walks the safe through entry, open, error and lockout states. Button inputs arrive already debounced and converted to single-cycle pulses.

## Interface

Parameters:
- `ERR_CYCLES`, default 25_000_000: length of the error indication after a wrong step, in clock cycles (≥1).
- `LOCK_CYCLES`, default 500_000_000: length of the lockout after `MAX_TRIES` consecutive failures, in clock cycles (≥1).
- `MAX_TRIES`, default 3: number of consecutive failed attempts that triggers lockout (1..15).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `btn_up`, input, 1: one-cycle pulse that increments the dial.
- `btn_down`, input, 1: one-cycle pulse that decrements the dial.
- `btn_enter`, input, 1: one-cycle pulse that confirms the current step, or closes the safe when it is open.
- `eq`, input, 1: comparator result for the current `bcd0`/`bcd1`/`sel`. It is combinational and valid in the same cycle.
- `bcd0`, output, 4: dial units digit, 0..9, registered.
- `bcd1`, output, 4: dial tens digit, 0..9, registered.
- `sel`, output, 2: current step index, 0..2, registered.
- `unlocked`, output, 1: high while in OPEN.
- `error`, output, 1: high while in ERROR.
- `locked_out`, output, 1: high while in LOCKOUT.

## Operation

States:
- ENTRY is the only state in which dial buttons have effect.

Dial behaviour (ENTRY only):
- Dial is a 00..99 BCD counter.
- `btn_up`: 99 wraps to 00. Units carry into tens (09 → 10).
- `btn_down`: 00 wraps to 99. Units borrow from tens (10 → 09).
- `btn_up` and `btn_down` in the same cycle: no change.
- `btn_enter` has priority. In a cycle with `btn_enter`, up/down are ignored.
- Outside ENTRY, all dial buttons are ignored and the dial holds 00.

`btn_enter` in ENTRY (decision uses `eq` sampled in the same cycle):
- `eq`=1 and `sel`<2: `sel` increments and the dial clears to 00.
- `eq`=1 and `sel`=2: go to OPEN. `sel` and dial clear to 0 and `fail_cnt` clears.
- `eq`=0: `fail_cnt` increments. `sel` and dial clear to 0.
  - If the new `fail_cnt` equals `MAX_TRIES`, go to LOCKOUT.
  - Otherwise go to ERROR.

ERROR:
- A down-counter loaded with `ERR_CYCLES`-1 runs to 0, then the block returns to ENTRY.
- `fail_cnt` is retained.

LOCKOUT:
- The same counter mechanism is used, with `LOCK_CYCLES`.
- On exit, `fail_cnt` clears and the block returns to ENTRY.
- `btn_enter` is ignored.

OPEN:
- `btn_enter` returns to ENTRY with `sel`=0.
- All other inputs are ignored.

Widths:
- The timer is `$clog2(LOCK_CYCLES)` bits wide, shared between ERROR and LOCKOUT.
- `fail_cnt` is 4 bits.

Outputs:
- `unlocked`, `error` and `locked_out` are decoded from the state register, so they are glitch-free.
- At most one of them is high at any time.

## Timing

Reset:
- While `rst_n`=0, asynchronously: state=ENTRY, `bcd0`=`bcd1`=0, `sel`=0, `unlocked`=`error`=`locked_out`=0, `fail_cnt`=0, timer=0.
- Reset mid-ERROR, mid-LOCKOUT or while OPEN returns to ENTRY immediately and clears the failure history.

Latencies:
- A button pulse at edge N is visible on the outputs after edge N.
- `eq` is sampled at the edge where `btn_enter` is seen, so the comparator path is one combinational stage within the cycle.
- `error` stays high for exactly `ERR_CYCLES` cycles.
- `locked_out` stays high for exactly `LOCK_CYCLES` cycles.
- ENTRY resumes on the next cycle after either of those windows ends.
- Buttons arriving on the first ENTRY cycle after ERROR or LOCKOUT are honoured.

## Test plan

The bench uses `ERR_CYCLES`=4, `LOCK_CYCLES`=10, `MAX_TRIES`=3, and a comparator model accepting 25, 30, 25 for steps 0, 1, 2.

1. Dial wrap and carry:
   - From reset, 1 `btn_down` → dial 99.
   - 1 `btn_up` → 00.
   - 10 `btn_up` → `bcd1`=1, `bcd0`=0.
   - Simultaneous up and down → dial unchanged.
2. Correct code:
   - Dial 25, enter → `sel`=1, dial 00.
   - Dial 30, enter → `sel`=2.
   - Dial 25, enter → `unlocked`=1 on the next cycle, `sel`=0.
   - Enter again → `unlocked`=0.
3. Wrong step:
   - Dial 25, enter (`sel`=1), then dial 31, enter → `error`=1 for exactly 4 cycles, `sel`=0, dial 00.
   - Dial buttons during ERROR have no effect.
4. Lockout:
   - Three consecutive wrong entries → third one yields `locked_out`=1 for exactly 10 cycles.
   - Afterwards one more wrong entry → ERROR, not LOCKOUT, proving `fail_cnt` cleared.
5. Priority:
   - `btn_enter` and `btn_up` together at dial 25, `sel`=0 → step advances and dial becomes 00, not 26.
6. Reset mid-lockout:
   - Assert `rst_n`=0 on cycle 5 of LOCKOUT → all outputs 0 asynchronously.
   - After release, a correct 25/30/25 sequence opens the safe.

Source files
------------

// File: rtl/code_entry_ctrl.sv
// Three-step safe code entry sequencer: BCD dial, step index, open/error/lockout timing.
// Latency: button pulse seen at edge N is reflected on registered outputs after edge N.
// No backpressure: single-cycle button pulses are consumed on the edge they arrive.
module code_entry_ctrl #(
    parameter int unsigned ERR_CYCLES  = 25_000_000,
    parameter int unsigned LOCK_CYCLES = 500_000_000,
    parameter int unsigned MAX_TRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       eq,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [1:0] sel,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out
);

    // Timer is sized for the longer (lockout) window and shared with the error window.
    localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TW-1:0] ERR_LOAD  = TW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] T_ZERO    = '0;
    localparam logic [3:0]    MAX_T     = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_OPEN  = 2'd1,
        S_ERROR = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    bcd0_q, bcd0_d;
    logic [3:0]    bcd1_q, bcd1_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    up0, up1, dn0, dn1;
    logic [3:0]    fail_inc;

    // Incremented / decremented BCD dial values with carry, borrow and 99<->00 wrap.
    always_comb begin
        up0 = bcd0_q + 4'd1;
        up1 = bcd1_q;
        if (bcd0_q == 4'd9) begin
            up0 = 4'd0;
            up1 = (bcd1_q == 4'd9) ? 4'd0 : bcd1_q + 4'd1;
        end
        dn0 = bcd0_q - 4'd1;
        dn1 = bcd1_q;
        if (bcd0_q == 4'd0) begin
            dn0 = 4'd9;
            dn1 = (bcd1_q == 4'd0) ? 4'd9 : bcd1_q - 4'd1;
        end
    end

    assign fail_inc = fail_q + 4'd1;

    // Next-state logic: entry decisions on confirm, timed error/lockout windows.
    always_comb begin
        state_d = state_q;
        bcd0_d  = bcd0_q;
        bcd1_d  = bcd1_q;
        sel_d   = sel_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            S_ENTRY: begin
                if (btn_enter) begin
                    // Confirm wins over any dial press in the same cycle.
                    bcd0_d = 4'd0;
                    bcd1_d = 4'd0;
                    sel_d  = 2'd0;
                    if (eq) begin
                        if (sel_q == 2'd2) begin
                            state_d = S_OPEN;
                            fail_d  = 4'd0;
                        end else begin
                            sel_d = sel_q + 2'd1;
                        end
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == MAX_T) begin
                            state_d = S_LOCK;
                            timer_d = LOCK_LOAD;
                        end else begin
                            state_d = S_ERROR;
                            timer_d = ERR_LOAD;
                        end
                    end
                end else if (btn_up && !btn_down) begin
                    bcd0_d = up0;
                    bcd1_d = up1;
                end else if (btn_down && !btn_up) begin
                    bcd0_d = dn0;
                    bcd1_d = dn1;
                end
            end
            S_OPEN: begin
                if (btn_enter) begin
                    state_d = S_ENTRY;
                end
            end
            S_ERROR: begin
                // Failure history is kept so consecutive misses can escalate to lockout.
                if (timer_q == T_ZERO) begin
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_LOCK: begin
                if (timer_q == T_ZERO) begin
                    state_d = S_ENTRY;
                    fail_d  = 4'd0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: begin
                state_d = S_ENTRY;
            end
        endcase
    end

    // State and datapath registers; reset returns to a clean entry with no failure history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ENTRY;
            bcd0_q  <= 4'd0;
            bcd1_q  <= 4'd0;
            sel_q   <= 2'd0;
            fail_q  <= 4'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            bcd0_q  <= bcd0_d;
            bcd1_q  <= bcd1_d;
            sel_q   <= sel_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign bcd0       = bcd0_q;
    assign bcd1       = bcd1_q;
    assign sel        = sel_q;
    assign unlocked   = (state_q == S_OPEN);
    assign error      = (state_q == S_ERROR);
    assign locked_out = (state_q == S_LOCK);

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Self-checking bench for code_entry_ctrl with a scoreboard of expected output snapshots.
// Each driven cycle pushes its expected post-edge outputs; they are popped and compared 1ns after the edge.
// Comparator model accepts 25, 30, 25 for steps 0, 1, 2.
module tb_code_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_enter, eq;
    logic [3:0] bcd0, bcd1;
    logic [1:0] sel;
    logic       unlocked, error, locked_out;
    logic [12:0] obs;

    int n_chk  = 0;
    int n_fail = 0;
    int m_dial = 0;
    int m_sel  = 0;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    code_entry_ctrl #(
        .ERR_CYCLES (4),
        .LOCK_CYCLES(10),
        .MAX_TRIES  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_enter (btn_enter),
        .eq        (eq),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .sel       (sel),
        .unlocked  (unlocked),
        .error     (error),
        .locked_out(locked_out)
    );

    // Comparator model: code 25 / 30 / 25.
    always_comb begin
        int d;
        d  = int'(bcd1) * 10 + int'(bcd0);
        eq = (sel == 2'd0 && d == 25) || (sel == 2'd1 && d == 30) || (sel == 2'd2 && d == 25);
    end

    assign obs = {bcd1, bcd0, sel, unlocked, error, locked_out};

    function automatic logic [12:0] pk(int dial, int s, logic u, logic e, logic l);
        return {4'(dial / 10), 4'(dial % 10), 2'(s), u, e, l};
    endfunction

    task automatic check(string tag, logic [12:0] got, logic [12:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got {bcd1,bcd0,sel,unl,err,lock}=%h required %h", tag, got, want);
        end
    endtask

    task automatic drive(logic up, logic dn, logic en, string tag, logic [12:0] expv);
        exp_t e;
        btn_up    = up;
        btn_down  = dn;
        btn_enter = en;
        sb.push_back('{tag, expv});
        @(posedge clk);
        #1;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_enter = 1'b0;
        e = sb.pop_front();
        check(e.tag, obs, e.v);
    endtask

    task automatic press_up();
        m_dial = (m_dial + 1) % 100;
        drive(1'b1, 1'b0, 1'b0, "up", pk(m_dial, m_sel, 0, 0, 0));
    endtask

    task automatic press_down();
        m_dial = (m_dial + 99) % 100;
        drive(1'b0, 1'b1, 1'b0, "down", pk(m_dial, m_sel, 0, 0, 0));
    endtask

    task automatic set_dial(int target);
        while (m_dial != target) press_up();
    endtask

    // Correct entry at the current step.
    task automatic enter_ok(string tag);
        if (m_sel < 2) begin
            m_sel++;
            m_dial = 0;
            drive(1'b0, 1'b0, 1'b1, tag, pk(0, m_sel, 0, 0, 0));
        end else begin
            m_sel  = 0;
            m_dial = 0;
            drive(1'b0, 1'b0, 1'b1, tag, pk(0, 0, 1, 0, 0));
        end
    endtask

    task automatic enter_bad(string tag, logic to_lock);
        m_sel  = 0;
        m_dial = 0;
        drive(1'b0, 1'b0, 1'b1, tag, pk(0, 0, 0, !to_lock, to_lock));
    endtask

    // Remaining 3 error cycles (dial presses ignored), then the first entry cycle.
    task automatic err_window(string tag);
        drive(1'b1, 1'b0, 1'b0, tag, pk(0, 0, 0, 1, 0));
        drive(1'b0, 1'b1, 1'b0, tag, pk(0, 0, 0, 1, 0));
        drive(1'b1, 1'b0, 1'b1, tag, pk(0, 0, 0, 1, 0));
        drive(1'b0, 1'b0, 1'b0, {tag, "_exit"}, pk(0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async", obs, 13'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_dial = 0;
        m_sel  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_enter = 1'b0;
        #2;
        check("reset_state", obs, 13'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Dial wrap and carry
        press_down();                          // 00 -> 99
        check("wrap_down", obs, pk(99, 0, 0, 0, 0));
        press_up();                            // 99 -> 00
        for (int i = 0; i < 10; i++) press_up();
        check("carry_10", obs, {4'd1, 4'd0, 2'd0, 3'b000});
        drive(1'b1, 1'b1, 1'b0, "up_and_down", pk(10, 0, 0, 0, 0));
        press_down();                          // 10 -> 09 borrow
        check("borrow_09", obs, {4'd0, 4'd9, 2'd0, 3'b000});

        // 2. Correct code, then close
        set_dial(25);
        enter_ok("step0_ok");
        set_dial(30);
        enter_ok("step1_ok");
        set_dial(25);
        enter_ok("open");
        drive(1'b1, 1'b0, 1'b0, "open_up_ignored", pk(0, 0, 1, 0, 0));
        drive(1'b0, 1'b1, 1'b0, "open_dn_ignored", pk(0, 0, 1, 0, 0));
        drive(1'b0, 1'b0, 1'b1, "close", pk(0, 0, 0, 0, 0));

        // 3. Wrong second step -> 4-cycle error window; buttons on first entry cycle honoured
        set_dial(25);
        enter_ok("t3_step0");
        set_dial(31);
        enter_bad("t3_wrong", 1'b0);
        err_window("t3_err");
        press_up();
        press_down();

        // 4. Three consecutive failures -> 10-cycle lockout; history cleared afterwards
        do_reset();
        enter_bad("t4_wrong1", 1'b0);
        err_window("t4_err1");
        enter_bad("t4_wrong2", 1'b0);
        err_window("t4_err2");
        enter_bad("t4_wrong3", 1'b1);
        for (int i = 0; i < 9; i++)
            drive(1'b1, 1'b0, (i % 2) == 0, "t4_lock", pk(0, 0, 0, 0, 1));
        drive(1'b0, 1'b0, 1'b0, "t4_lock_exit", pk(0, 0, 0, 0, 0));
        enter_bad("t4_after_lock", 1'b0);
        err_window("t4_err4");

        // 5. Enter has priority over up
        set_dial(25);
        m_sel  = 1;
        m_dial = 0;
        drive(1'b1, 1'b0, 1'b1, "enter_priority", pk(0, 1, 0, 0, 0));

        // 6. Reset on cycle 5 of lockout, then open the safe
        enter_bad("t6_wrong2", 1'b0);          // fail history now 2
        err_window("t6_err");
        enter_bad("t6_wrong3", 1'b1);          // lockout cycle 1
        for (int i = 0; i < 4; i++)            // lockout cycles 2..5
            drive(1'b0, 1'b0, 1'b0, "t6_lock", pk(0, 0, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_async", obs, 13'd0);
        @(posedge clk);
        #1;
        check("t6_rst_hold", obs, 13'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_dial = 0;
        m_sel  = 0;
        set_dial(25);
        enter_ok("t6_step0");
        set_dial(30);
        enter_ok("t6_step1");
        set_dial(25);
        enter_ok("t6_open");
        check("sb_empty", 13'(sb.size()), 13'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
